pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage register for the 5-stage pipeline, replacing the fixed-field, always-load stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake so stalls propagate, a synchronous flush that inserts a bubble, an optional skid entry that keeps full throughput with registered ready, and a saturating stall-cycle counter for performance debug.
- Control fields (RegWrite, ResultSrc, ...) and datapath fields (ALUResult, PCPlus4, ...) are carried as separate flat vectors, so a bubble clears only the control bits.

Parameters:
- CTRL_W, 8, width of the control-field vector; a bubble forces it to CTRL_BUBBLE.
- DATA_W, 128, width of the datapath-field vector (concatenated 32-bit fields plus Rd).
- CTRL_BUBBLE, 0, value of out_ctrl when the stage holds a bubble or is in reset. Its width is CTRL_W.
- SKID, 1, selects the buffering mode.
  - 1: two-entry skid buffer with registered in_ready.
  - 0: single register with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream stage presents a beat.
- in_ready  output  1  this stage accepts a beat this cycle.
- in_ctrl  input  CTRL_W  upstream control fields.
- in_data  input  DATA_W  upstream datapath fields.
- flush  input  1  synchronous kill of all held and incoming beats (branch mispredict or jump).
- out_valid  output  1  stage holds a valid beat.
- out_ready  input  1  downstream stage can take the beat (not stalled).
- out_ctrl  output  CTRL_W  registered control fields.
- out_data  output  DATA_W  registered datapath fields.
- stall_cnt  output  CNT_W  count of stalled cycles.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous release):
  - out_valid=0, out_ctrl=CTRL_BUBBLE, out_data=0.
  - Skid entry empty, stall_cnt=0.
  - in_ready=1 on the first clock after release.
  - Reset mid-transfer discards all held beats, with no partial update.
- Transfers:
  - Accept on a clock edge where in_valid and in_ready are both 1.
  - Deliver on a clock edge where out_valid and out_ready are both 1.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput is one beat per cycle while out_ready=1.
- SKID=1:
  - Main register drives the outputs; the skid register holds at most one overflow beat.
  - in_ready = !skid_valid, taken straight from a flop with no combinational path from out_ready.
  - If an accept occurs while main is valid and out_ready=0, the beat goes to skid. in_ready drops the next cycle.
  - When the main beat is delivered and skid is valid, skid moves to main and skid empties. A simultaneous accept is impossible because in_ready=0.
  - When the main beat is delivered, skid is empty, and an accept occurs, the new beat loads main directly.
- SKID=0:
  - in_ready = out_ready | !out_valid (combinational).
  - Main loads on accept and holds otherwise.
- Stall: while out_valid=1 and out_ready=0, out_ctrl and out_data hold stable, bit for bit.
- No beat is ever dropped or duplicated. Order is strictly FIFO.
- Flush (highest priority after reset):
  - On a clock edge with flush=1, main and skid are both invalidated.
  - out_ctrl is set to CTRL_BUBBLE; out_data holds its previous value (don't-care).
  - A beat offered in the same cycle is discarded even though in_ready may read 1.
  - in_ready=1 in the following cycle.
- Bubble rule: whenever out_valid=0, out_ctrl must equal CTRL_BUBBLE. Downstream can therefore ignore out_valid for write-enable safety.
- stall_cnt:
  - Increments on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment.
  - Flush does not clear it.

Test Plan:
- Reset sequence: hold rst_n=0 for 3 cycles, then release → out_valid=0, out_ctrl=CTRL_BUBBLE(0x00), stall_cnt=0, in_ready=1.
- Streaming with SKID=1 and out_ready=1: beats ctrl=0x01..0x08, data=i*4 for i=1..8, over 8 consecutive cycles → the same 8 beats emerge in order, 1 cycle later, with no gaps.
- Stall:
  - Stimulus: beat A (data 0x100) accepted, then out_ready=0 for 4 cycles while beat B (data 0x200) is offered.
  - Response: B enters skid and in_ready=0 from the next cycle. out_data stays 0x100 throughout. stall_cnt=4.
  - Release out_ready → A, then B delivered; in_ready returns to 1.
- Flush while full: main and skid both valid, flush=1 with in_valid=1 carrying C → next cycle out_valid=0, out_ctrl=0x00, in_ready=1; C is never delivered.
- SKID=0 instance:
  - out_ready=0 with out_valid=1 → in_ready=0 in the same cycle.
  - out_ready=1 and in_valid=1 → replacement beat visible next cycle.
- Counter edge cases:
  - With CNT_W=4, stall for 20 cycles → stall_cnt=15 (saturated).
  - Assert stall_clr together with a stall cycle → stall_cnt=0.
  - Assert rst_n=0 mid-stall → all state cleared asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register for the 5-stage pipeline.
// Carries a control vector and a datapath vector between stages with a
// valid/ready handshake. A flush inserts a bubble, which clears only the
// control vector. An optional skid entry keeps full throughput while in_ready
// stays registered. A saturating counter records stalled cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_ctrl/in_data       upstream control and datapath fields
//   flush                 synchronous kill of held and incoming beats
//   out_valid/out_ready   downstream handshake
//   out_ctrl/out_data     registered control and datapath fields
//   stall_cnt/stall_clr   stalled-cycle counter and its synchronous clear
module pipe_stage_reg #(
   parameter int                CTRL_W      = 8,
   parameter int                DATA_W      = 128,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter int                SKID        = 1,
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              stall_clr
);

   logic              mainValid;
   logic [CTRL_W-1:0] mainCtrl;
   logic [DATA_W-1:0] mainData;
   logic              accept;
   logic [CNT_W-1:0]  stallCnt;

   assign accept = in_valid & in_ready;

   generate
      if (SKID != 0) begin : gSkid
         logic              skidValid;
         logic [CTRL_W-1:0] skidCtrl;
         logic [DATA_W-1:0] skidData;
         logic              skidLoad;

         // in_ready comes straight from the skid flop, so no path from out_ready.
         assign in_ready = !skidValid;
         // An accept while main is stalled can only land in skid.
         assign skidLoad = accept & mainValid & !out_ready & !flush;

         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the pre-edge values, independent of statement order.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mainValid <= 1'b0;
               mainCtrl  <= CTRL_BUBBLE;
               mainData  <= '0;
               skidValid <= 1'b0;
            end else if (flush) begin
               // Data is left as-is: with valid low it is a don't-care.
               mainValid <= 1'b0;
               mainCtrl  <= CTRL_BUBBLE;
               skidValid <= 1'b0;
            end else if (!mainValid || out_ready) begin
               // Main is free this edge (empty or delivering): refill it,
               // oldest beat first.
               if (skidValid) begin
                  mainValid <= 1'b1;
                  mainCtrl  <= skidCtrl;
                  mainData  <= skidData;
                  skidValid <= 1'b0;
               end else if (accept) begin
                  mainValid <= 1'b1;
                  mainCtrl  <= in_ctrl;
                  mainData  <= in_data;
               end else begin
                  mainValid <= 1'b0;
                  mainCtrl  <= CTRL_BUBBLE;
               end
            end else if (accept) begin
               skidValid <= 1'b1;
            end
         end

         // NOTE: the skid payload has no reset; it is only read while
         // skidValid is set, and skidValid itself is reset.
         always_ff @(posedge clk) begin
            if (skidLoad) begin
               skidCtrl <= in_ctrl;
               skidData <= in_data;
            end
         end
      end else begin : gNoSkid
         assign in_ready = out_ready | !mainValid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mainValid <= 1'b0;
               mainCtrl  <= CTRL_BUBBLE;
               mainData  <= '0;
            end else if (flush) begin
               mainValid <= 1'b0;
               mainCtrl  <= CTRL_BUBBLE;
            end else if (accept) begin
               mainValid <= 1'b1;
               mainCtrl  <= in_ctrl;
               mainData  <= in_data;
            end else if (out_ready) begin
               mainValid <= 1'b0;
               mainCtrl  <= CTRL_BUBBLE;
            end
         end
      end
   endgenerate

   // Saturating stall counter; clear beats increment, flush leaves it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt <= '0;
      end else if (stall_clr) begin
         stallCnt <= '0;
      end else if (mainValid && !out_ready && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign out_valid = mainValid;
   assign out_ctrl  = mainCtrl;
   assign out_data  = mainData;
   assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. A SKID=1 instance (CNT_W=4) and a SKID=0
// instance (CNT_W=16) receive identical stimulus. Each has a FIFO-queue
// reference model of the beats it holds plus a saturating stall-count model.
module tb_pipe_stage_reg;

   typedef struct {
      logic [7:0]   c;
      logic [127:0] d;
   } beat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         inValid = 1'b0;
   logic [7:0]   inCtrl = '0;
   logic [127:0] inData = '0;
   logic         flush = 1'b0;
   logic         outReady = 1'b1;
   logic         stallClr = 1'b0;

   logic         inReady1, outValid1, inReady0, outValid0;
   logic [7:0]   outCtrl1, outCtrl0;
   logic [127:0] outData1, outData0;
   logic [3:0]   stallCnt1;
   logic [15:0]  stallCnt0;

   int checks = 0;
   int failures = 0;

   beat_t q1[$];
   beat_t q0[$];
   int    cnt1 = 0;
   int    cnt0 = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CTRL_BUBBLE(8'h00), .SKID(1), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady1),
      .in_ctrl(inCtrl), .in_data(inData), .flush(flush), .out_valid(outValid1),
      .out_ready(outReady), .out_ctrl(outCtrl1), .out_data(outData1),
      .stall_cnt(stallCnt1), .stall_clr(stallClr)
   );

   pipe_stage_reg #(.CTRL_W(8), .DATA_W(128), .CTRL_BUBBLE(8'h00), .SKID(0), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid), .in_ready(inReady0),
      .in_ctrl(inCtrl), .in_data(inData), .flush(flush), .out_valid(outValid0),
      .out_ready(outReady), .out_ctrl(outCtrl0), .out_data(outData0),
      .stall_cnt(stallCnt0), .stall_clr(stallClr)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare both DUTs against their models (called away from the clock edge).
   task automatic checkModels();
      check("s1_in_ready", inReady1, q1.size() < 2);
      check("s1_out_valid", outValid1, q1.size() > 0);
      check("s1_out_ctrl", outCtrl1, (q1.size() > 0) ? q1[0].c : 8'h00);
      if (q1.size() > 0) check("s1_out_data", outData1, q1[0].d);
      check("s1_stall_cnt", stallCnt1, cnt1);
      check("s0_in_ready", inReady0, outReady || (q0.size() == 0));
      check("s0_out_valid", outValid0, q0.size() > 0);
      check("s0_out_ctrl", outCtrl0, (q0.size() > 0) ? q0[0].c : 8'h00);
      if (q0.size() > 0) check("s0_out_data", outData0, q0[0].d);
      check("s0_stall_cnt", stallCnt0, cnt0);
   endtask

   // One clock cycle: starts and ends just after a falling edge.
   task automatic cycle(input logic iv, input logic [7:0] ic, input logic [127:0] id,
                        input logic fl, input logic ordy, input logic clr);
      bit    acc1, acc0, stall1, stall0, dlv1, dlv0;
      beat_t b;
      inValid  = iv;
      inCtrl   = ic;
      inData   = id;
      flush    = fl;
      outReady = ordy;
      stallClr = clr;
      #1;
      checkModels();
      b.c    = ic;
      b.d    = id;
      acc1   = iv && (q1.size() < 2);
      acc0   = iv && (ordy || (q0.size() == 0));
      dlv1   = (q1.size() > 0) && ordy;
      dlv0   = (q0.size() > 0) && ordy;
      stall1 = (q1.size() > 0) && !ordy;
      stall0 = (q0.size() > 0) && !ordy;
      @(posedge clk);
      if (fl) begin
         q1.delete();
         q0.delete();
      end else begin
         if (dlv1) void'(q1.pop_front());
         if (acc1) q1.push_back(b);
         if (dlv0) void'(q0.pop_front());
         if (acc0) q0.push_back(b);
      end
      if (clr) cnt1 = 0; else if (stall1 && cnt1 < 15) cnt1++;
      if (clr) cnt0 = 0; else if (stall0 && cnt0 < 65535) cnt0++;
      @(negedge clk);
   endtask

   // Asynchronous reset between edges; outputs must clear before any clock.
   task automatic doReset();
      inValid  = 1'b0;
      flush    = 1'b0;
      stallClr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_s1_out_valid", outValid1, 1'b0);
      check("rst_s1_out_ctrl", outCtrl1, 8'h00);
      check("rst_s1_out_data", outData1, 128'h0);
      check("rst_s1_stall_cnt", stallCnt1, 4'h0);
      check("rst_s0_out_valid", outValid0, 1'b0);
      check("rst_s0_out_ctrl", outCtrl0, 8'h00);
      check("rst_s0_out_data", outData0, 128'h0);
      check("rst_s0_stall_cnt", stallCnt0, 16'h0);
      q1.delete();
      q0.delete();
      cnt1 = 0;
      cnt0 = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset and first post-release state.
      doReset();
      cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b1, 1'b0);

      // Streaming eight back-to-back beats.
      for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 128'(i * 4), 1'b0, 1'b1, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b1, 1'b0);

      // Stall: A accepted, then B offered for four stalled cycles.
      cycle(1'b1, 8'h0A, 128'h100, 1'b0, 1'b1, 1'b0);
      repeat (4) cycle(1'b1, 8'h0B, 128'h200, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b1, 1'b0);

      // Flush while main and skid are both full, with C offered.
      cycle(1'b1, 8'h11, 128'h300, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h12, 128'h400, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h13, 128'h500, 1'b1, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b1, 1'b0);

      // Counter saturation, then clear concurrent with a stall.
      cycle(1'b1, 8'h21, 128'h600, 1'b0, 1'b1, 1'b1);
      repeat (20) cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a stall.
      doReset();
      cycle(1'b0, 8'h00, 128'h0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic against the models.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            doReset();
         end else begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom),
                  {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 19) == 0, $urandom_range(0, 4) < 3,
                  $urandom_range(0, 29) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
